pipeline_subtractor: RTL and testbench

PIPELINE_SUBTRACTOR -- requirements
Module: pipeline_subtractor

---
 rtl/pipeline_subtractor.sv | 118 +++++++++++
 tb/tb_pipeline_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_subtractor.sv
// ---------------------------------------------------------------------------
// pipeline_subtractor
//
// Four-stage pipelined unsigned subtractor: d = (a - b - bi) mod 2^WIDTH,
// bo = 1 when a < b + bi. The operands are cut into four C = WIDTH/4 bit
// chunks. Stage k subtracts chunk k using the borrow registered by stage
// k-1, so the longest combinational path is a single C-bit subtract.
// Upper operand chunks are skewed in, and lower result chunks are deskewed
// out, so that every chunk of a result lands on d on the same edge.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears every register
//   en         pipeline advance enable; 0 holds all registers
//   in_valid   a/b/bi carry an operation this cycle
//   a, b       unsigned minuend / subtrahend, WIDTH bits
//   bi         borrow-in
//   d          registered difference
//   bo         registered borrow-out
//   out_valid  registered, marks d/bo as holding a result
//
// Latency is four enabled edges. A new operation is accepted every enabled
// cycle. WIDTH must be a multiple of 4 and at least 8.
// ---------------------------------------------------------------------------
module pipeline_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             out_valid
);

    localparam int C = WIDTH / 4;

    // One chunk of the subtract. The extra MSB of the (C+1)-bit result is
    // the borrow: it is set exactly when x < y + bin.
    function automatic logic [C:0] sub_chunk(input logic [C-1:0] x,
                                             input logic [C-1:0] y,
                                             input logic         bin);
        return {1'b0, x} - {1'b0, y} - {{C{1'b0}}, bin};
    endfunction

    logic [3*C-1:0] a_hi_p0, b_hi_p0;
    logic [C-1:0]   d_lo_p0;
    logic           br_p0, vld_p0;

    logic [2*C-1:0] a_hi_p1, b_hi_p1;
    logic [2*C-1:0] d_lo_p1;
    logic           br_p1, vld_p1;

    logic [C-1:0]   a_hi_p2, b_hi_p2;
    logic [3*C-1:0] d_lo_p2;
    logic           br_p2, vld_p2;

    logic [C:0]     s0, s1, s2, s3;

    assign s0 = sub_chunk(a[C-1:0],          b[C-1:0],          bi);
    assign s1 = sub_chunk(a_hi_p0[C-1:0],    b_hi_p0[C-1:0],    br_p0);
    assign s2 = sub_chunk(a_hi_p1[C-1:0],    b_hi_p1[C-1:0],    br_p1);
    assign s3 = sub_chunk(a_hi_p2,           b_hi_p2,           br_p2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hi_p0   <= '0;
            b_hi_p0   <= '0;
            d_lo_p0   <= '0;
            br_p0     <= 1'b0;
            vld_p0    <= 1'b0;
            a_hi_p1   <= '0;
            b_hi_p1   <= '0;
            d_lo_p1   <= '0;
            br_p1     <= 1'b0;
            vld_p1    <= 1'b0;
            a_hi_p2   <= '0;
            b_hi_p2   <= '0;
            d_lo_p2   <= '0;
            br_p2     <= 1'b0;
            vld_p2    <= 1'b0;
            d         <= '0;
            bo        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            // Stage 0: chunk 0, upper three chunks skewed by one level
            a_hi_p0   <= a[WIDTH-1:C];
            b_hi_p0   <= b[WIDTH-1:C];
            d_lo_p0   <= s0[C-1:0];
            br_p0     <= s0[C];
            vld_p0    <= in_valid;

            // Stage 1: chunk 1, chunk 0 result carried along
            a_hi_p1   <= a_hi_p0[3*C-1:C];
            b_hi_p1   <= b_hi_p0[3*C-1:C];
            d_lo_p1   <= {s1[C-1:0], d_lo_p0};
            br_p1     <= s1[C];
            vld_p1    <= vld_p0;

            // Stage 2: chunk 2
            a_hi_p2   <= a_hi_p1[2*C-1:C];
            b_hi_p2   <= b_hi_p1[2*C-1:C];
            d_lo_p2   <= {s2[C-1:0], d_lo_p1};
            br_p2     <= s2[C];
            vld_p2    <= vld_p1;

            // Stage 3: chunk 3, all chunks meet on the output register
            d         <= {s3[C-1:0], d_lo_p2};
            bo        <= s3[C];
            out_valid <= vld_p2;
        end
    end

endmodule

// File: tb/tb_pipeline_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipeline_subtractor
//
// Scoreboard bench for pipeline_subtractor (WIDTH = 32). The driver pushes
// the expected {d, bo} together with the enabled-edge count at which the
// result must appear; a monitor on the falling edge pops and compares each
// newly presented result.
// ---------------------------------------------------------------------------
module tb_pipeline_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bi = 1'b0;
    logic [31:0] d;
    logic        bo;
    logic        out_valid;

    always #5 clk = ~clk;

    pipeline_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .d         (d),
        .bo        (bo),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [31:0] d;
        logic        bo;
        int          edg;
    } exp_t;

    exp_t sbq[$];

    int tests  = 0;
    int fails  = 0;
    int ecount = 0;
    bit last_en = 1'b0;
    int vcount = 0;
    int rises  = 0;
    bit prev_ov = 1'b0;

    // Enabled-edge counter, used to verify the exact latency.
    always @(posedge clk) begin
        if (en && !rst) ecount++;
        last_en = en && !rst;
    end

    // Monitor: a fresh result is present after an enabled edge with out_valid.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !prev_ov) rises++;
        if (out_valid === 1'b1) vcount++;
        prev_ov = (out_valid === 1'b1);
        if (!rst && last_en && out_valid === 1'b1) begin : pop
            exp_t e;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got d=%h bo=%b at edge %0d, required no output",
                         d, bo, ecount);
            end else begin
                e = sbq.pop_front();
                if (d !== e.d || bo !== e.bo || ecount != e.edg) begin
                    fails++;
                    $display("FAIL result: got d=%h bo=%b edge=%0d, required d=%h bo=%b edge=%0d",
                             d, bo, ecount, e.d, e.bo, e.edg);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Reference built on an adder: a + ~b + !bi, borrow is the inverted carry.
    function automatic logic [32:0] adder_ref(input logic [31:0] x, input logic [31:0] y,
                                              input logic bin);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, ~y} + 33'(!bin);
        return {~s[32], s[31:0]};
    endfunction

    // Drive one operation on the falling edge and record its expectation.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ibi,
                         input logic [31:0] ed, input logic ebo);
        exp_t e;
        a = ia; b = ib; bi = ibi; in_valid = 1'b1; en = 1'b1;
        e.d = ed; e.bo = ebo; e.edg = ecount + 4;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue_ref(input logic [31:0] ia, input logic [31:0] ib, input logic ibi);
        logic [32:0] r;
        r = adder_ref(ia, ib, ibi);
        issue(ia, ib, ibi, r[31:0], r[32]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0; en = 1'b1;
            a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    // Directed vectors with hand-computed results.
    logic [31:0] da [8] = '{32'h30561C86, 32'h00000000, 32'h00000000, 32'h12345678,
                            32'h12345678, 32'h00000005, 32'hFFFFFFFF, 32'h00010000};
    logic [31:0] db [8] = '{32'h00002475, 32'h00000001, 32'hFFFFFFFF, 32'h12345678,
                            32'h12345678, 32'h00000003, 32'hFFFFFFFF, 32'h00000001};
    logic        dbi[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dd [8] = '{32'h3055F811, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
                            32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h0000FFFF};
    logic        dbo[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic [31:0] sd;
    logic        sbo, sov;

    initial begin
        // Asynchronous reset, before any clock edge.
        #1 rst = 1'b1;
        en = 1'b1; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h1;
        #2;
        chk("reset_d",  64'(d),         64'h0);
        chk("reset_bo", 64'(bo),        64'h0);
        chk("reset_ov", 64'(out_valid), 64'h0);

        // en and in_valid must have no effect while rst is high.
        repeat (5) @(negedge clk);
        chk("reset_en_ignored_ov", 64'(out_valid), 64'h0);
        chk("reset_en_ignored_d",  64'(d),         64'h0);
        rst = 1'b0; in_valid = 1'b0;

        // Directed vectors, back to back.
        for (int i = 0; i < 8; i++) issue(da[i], db[i], dbi[i], dd[i], dbo[i]);
        idle(6);

        // Back-to-back stream of 8, bi alternating.
        vcount = 0; rises = 0;
        for (int i = 0; i < 8; i++) issue_ref($urandom, $urandom, 1'(i % 2));
        idle(8);
        chk("stream_valid_cycles", 64'(vcount), 64'd8);
        chk("stream_valid_runs",   64'(rises),  64'd1);

        // Stall of three cycles mid-stream with changing inputs.
        for (int i = 0; i < 5; i++) issue_ref($urandom, $urandom, 1'(i % 2));
        sd = d; sbo = bo; sov = out_valid;
        chk("prestall_ov", 64'(sov), 64'h1);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; in_valid = 1'b1;
            a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_d",  64'(d),         64'(sd));
            chk("stall_bo", 64'(bo),        64'(sbo));
            chk("stall_ov", 64'(out_valid), 64'(sov));
        end
        for (int i = 0; i < 3; i++) issue_ref($urandom, $urandom, 1'(i % 2));
        idle(6);

        // Mid-stream reset with operations in flight.
        for (int i = 0; i < 3; i++) issue_ref($urandom | 32'h1, $urandom, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_d",  64'(d),         64'h0);
        chk("midrst_bo", 64'(bo),        64'h0);
        chk("midrst_ov", 64'(out_valid), 64'h0);
        sbq.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        idle(6);
        chk("postrst_no_stale_ov", 64'(out_valid), 64'h0);

        // First operation after reset: latency checked through the scoreboard.
        issue(32'h00000010, 32'h00000020, 1'b0, 32'hFFFFFFF0, 1'b1);
        idle(2);
        chk("postrst_not_early_ov", 64'(out_valid), 64'h0);
        idle(4);

        // Drain, bounded.
        for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
        chk("drain_queue_empty", 64'(sbq.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
